burst_line_adapter: RTL and testbench

BURST_LINE_ADAPTER -- requirements
Module: burst_line_adapter

---
 rtl/burst_line_adapter.sv | 105 ++++++++++
 tb/tb_burst_line_adapter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adapter.sv
// Cache-line <-> memory-burst adapter: one line moves as s_line/s_burst beats.
// Optional BURST_LINE_ADAPTER_POSTED_WRITE_EN acknowledges writes once latched.
module burst_line_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read,
    input  logic               line_write,
    input  logic [31:0]        line_address,
    input  logic [s_line-1:0]  line_wdata,
    output logic [s_line-1:0]  line_rdata,
    output logic               line_resp,
    output logic               burst_read,
    output logic               burst_write,
    output logic [31:0]        burst_address,
    output logic [s_burst-1:0] burst_wdata,
    input  logic [s_burst-1:0] burst_rdata,
    input  logic               burst_resp
);

    localparam int n_beats = s_line / s_burst;
    localparam int cw      = $clog2(n_beats);
    localparam logic [31:0] line_mask = ~32'(s_line / 8 - 1);
    localparam logic [cw-1:0] last_beat = cw'(n_beats - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_t;

    state_t            state;
    logic [cw-1:0]     beat;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;

    assign burst_address = addr_q;
    assign burst_wdata   = wdata_q[beat*s_burst +: s_burst];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            beat        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_rdata  <= '0;
            line_resp   <= 1'b0;
            burst_read  <= 1'b0;
            burst_write <= 1'b0;
        end else begin
            line_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Write wins so a dirty victim leaves before the fill.
                    if (line_write) begin
                        addr_q      <= line_address & line_mask;
                        wdata_q     <= line_wdata;
                        beat        <= '0;
                        burst_write <= 1'b1;
                        state       <= WR_BURST;
`ifdef BURST_LINE_ADAPTER_POSTED_WRITE_EN
                        line_resp   <= 1'b1;
`endif
                    end else if (line_read) begin
                        addr_q     <= line_address & line_mask;
                        beat       <= '0;
                        burst_read <= 1'b1;
                        state      <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        line_rdata[beat*s_burst +: s_burst] <= burst_rdata;
                        beat <= beat + 1'b1;
                        if (beat == last_beat) begin
                            burst_read <= 1'b0;
                            line_resp  <= 1'b1;
                            state      <= RD_DONE;
                        end
                    end
                end
                RD_DONE: state <= IDLE;
                WR_BURST: begin
                    if (burst_resp) begin
                        beat <= beat + 1'b1;
                        if (beat == last_beat) begin
                            burst_write <= 1'b0;
                            state       <= WR_DONE;
`ifndef BURST_LINE_ADAPTER_POSTED_WRITE_EN
                            line_resp   <= 1'b1;
`endif
                        end
                    end
                end
                WR_DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_line_adapter.sv
// Bench for burst_line_adapter: a beat-level memory model drives bursts and
// expected lines, addresses and response timing come from line-level rules.
module tb_burst_line_adapter;

    logic         clk;
    logic         rst;
    logic         line_read;
    logic         line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_resp;
    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    int checks = 0;
    int errors = 0;
    logic [255:0] last_line = '0;

    burst_line_adapter #(.s_line(256), .s_burst(64)) dut (
        .clk(clk),
        .rst(rst),
        .line_read(line_read),
        .line_write(line_write),
        .line_address(line_address),
        .line_wdata(line_wdata),
        .line_rdata(line_rdata),
        .line_resp(line_resp),
        .burst_read(burst_read),
        .burst_write(burst_write),
        .burst_address(burst_address),
        .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata),
        .burst_resp(burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        line_read = 1'b0;
        line_write = 1'b0;
        line_address = '0;
        line_wdata = '0;
        burst_rdata = '0;
        burst_resp = 1'b0;
        step();
        step();
        checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000",
                     {line_resp, burst_read, burst_write});
        end
        checks++;
        if (line_rdata !== '0 || burst_address !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata %h addr %h want 0",
                     line_rdata, burst_address);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] data,
                           input int gapmode, input string tag);
        int g;
        int bad = 0;
        line_read = 1'b1;
        line_write = 1'b0;
        line_address = addr;
        step();
        checks++;
        if (burst_read !== 1'b1 || burst_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: rd %b wr %b want 1 0",
                     tag, burst_read, burst_write);
        end
        checks++;
        if (burst_address !== (addr & 32'hFFFF_FFE0)) begin
            errors++;
            $display("FAIL %s_addr: got %h want %h",
                     tag, burst_address, addr & 32'hFFFF_FFE0);
        end
        for (int k = 0; k < 4; k++) begin
            g = (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode;
            repeat (g) begin
                burst_resp = 1'b0;
                burst_rdata = {$urandom, $urandom};
                step();
                if (line_resp !== 1'b0 || burst_read !== 1'b1) bad++;
            end
            burst_resp = 1'b1;
            burst_rdata = data[k*64 +: 64];
            step();
            if (k < 3 && (line_resp !== 1'b0 || burst_read !== 1'b1)) bad++;
        end
        burst_resp = 1'b0;
        burst_rdata = {$urandom, $urandom};
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_during: %0d bad cycles want 0", tag, bad);
        end
        checks++;
        if (line_resp !== 1'b1 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_resp: resp %b rd %b want 1 0",
                     tag, line_resp, burst_read);
        end
        checks++;
        if (line_rdata !== data) begin
            errors++;
            $display("FAIL %s_rdata: got %h want %h", tag, line_rdata, data);
        end
        line_read = 1'b0;
        last_line = data;
        step();
        checks++;
        if (line_resp !== 1'b0 || line_rdata !== data) begin
            errors++;
            $display("FAIL %s_idle: resp %b rdata %h want 0 %h",
                     tag, line_resp, line_rdata, data);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] data,
                            input logic also_read, input int gapmode,
                            input string tag);
        int g;
        int bad = 0;
        int resp_cnt = 0;
        line_write = 1'b1;
        line_read = also_read;
        line_address = addr;
        line_wdata = data;
        step();
        line_wdata = ~data;
`ifdef BURST_LINE_ADAPTER_POSTED_WRITE_EN
        checks++;
        if (line_resp !== 1'b1) begin
            errors++;
            $display("FAIL %s_posted: resp %b want 1", tag, line_resp);
        end
        line_write = 1'b0;
        line_read = 1'b0;
`endif
        checks++;
        if (burst_address !== (addr & 32'hFFFF_FFE0)) begin
            errors++;
            $display("FAIL %s_addr: got %h want %h",
                     tag, burst_address, addr & 32'hFFFF_FFE0);
        end
        for (int k = 0; k < 4; k++) begin
            g = (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode;
            repeat (g) begin
                burst_resp = 1'b0;
                if (line_resp === 1'b1) resp_cnt++;
                if (burst_write !== 1'b1 || burst_read !== 1'b0 ||
                    burst_wdata !== data[k*64 +: 64]) bad++;
                step();
            end
            burst_resp = 1'b1;
            if (line_resp === 1'b1) resp_cnt++;
            if (burst_write !== 1'b1 || burst_read !== 1'b0 ||
                burst_wdata !== data[k*64 +: 64]) bad++;
            step();
        end
        burst_resp = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_beats: %0d bad cycles want 0", tag, bad);
        end
        if (line_resp === 1'b1) resp_cnt++;
        checks++;
        if (burst_write !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: rd %b wr %b want 0 0",
                     tag, burst_read, burst_write);
        end
`ifdef BURST_LINE_ADAPTER_POSTED_WRITE_EN
        checks++;
        if (line_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_resp: got %b want 0", tag, line_resp);
        end
`else
        checks++;
        if (line_resp !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_resp: got %b want 1", tag, line_resp);
        end
`endif
        line_write = 1'b0;
        line_read = 1'b0;
        step();
        if (line_resp === 1'b1) resp_cnt++;
        checks++;
        if (resp_cnt != 1) begin
            errors++;
            $display("FAIL %s_resp_count: got %0d want 1", tag, resp_cnt);
        end
    endtask

    task automatic test_read_vector();
        logic [255:0] d;
        d = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_read(32'h0000_1234, d, 0, "read_vec");
    endtask

    task automatic test_write_gaps();
        do_write(32'h8000_0040, rand_line(), 1'b0, 1, "write_gap");
    endtask

    task automatic test_both_strobes();
        do_write(32'h0000_0040, rand_line(), 1'b1, -1, "both");
    endtask

    task automatic test_stray_resp();
        int bad = 0;
        burst_resp = 1'b1;
        repeat (3) begin
            burst_rdata = {$urandom, $urandom};
            step();
            if (line_resp !== 1'b0 || burst_read !== 1'b0 ||
                burst_write !== 1'b0 || line_rdata !== last_line) bad++;
        end
        burst_resp = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stray: %0d bad cycles want 0", bad);
        end
        do_read(32'h0000_2000, rand_line(), -1, "after_stray");
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] d;
        d = rand_line();
        line_read = 1'b1;
        line_address = 32'h0000_0300;
        step();
        for (int k = 0; k < 2; k++) begin
            burst_resp = 1'b1;
            burst_rdata = d[k*64 +: 64];
            step();
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({line_resp, burst_read, burst_write} !== 3'b000 ||
            line_rdata !== '0 || burst_address !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: ctrl %b rdata %h addr %h want 000 0 0",
                     {line_resp, burst_read, burst_write},
                     line_rdata, burst_address);
        end
        step();
        checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hold: resp %b rd %b want 0 0",
                     line_resp, burst_read);
        end
        burst_resp = 1'b0;
        line_read = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: resp %b rd %b want 0 0",
                     line_resp, burst_read);
        end
        do_read(32'h0000_0100, rand_line(), -1, "read_100");
    endtask

`ifdef BURST_LINE_ADAPTER_POSTED_WRITE_EN
    task automatic test_posted_then_read();
        logic [255:0] w;
        logic [255:0] r;
        int bad = 0;
        w = rand_line();
        r = rand_line();
        line_write = 1'b1;
        line_address = 32'h0000_0500;
        line_wdata = w;
        step();
        checks++;
        if (line_resp !== 1'b1) begin
            errors++;
            $display("FAIL posted_early: resp %b want 1", line_resp);
        end
        line_write = 1'b0;
        line_read = 1'b1;
        line_address = 32'h0000_0640;
        for (int k = 0; k < 4; k++) begin
            burst_resp = 1'b1;
            if (burst_read !== 1'b0 || burst_wdata !== w[k*64 +: 64]) bad++;
            step();
            if (line_resp !== 1'b0) bad++;
        end
        burst_resp = 1'b0;
        if (burst_read !== 1'b0) bad++;
        step();
        if (burst_read !== 1'b0 || line_resp !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL posted_stall: %0d bad cycles want 0", bad);
        end
        do_read(32'h0000_0640, r, -1, "posted_rd");
    endtask
`endif

    task automatic test_random_mix();
        int op;
        logic [31:0] a;
        for (int i = 0; i < 8; i++) begin
            op = int'($urandom_range(0, 2));
            a = $urandom;
            if (op == 0) do_read(a, rand_line(), -1, "rand_rd");
            else do_write(a, rand_line(), op == 2, -1, "rand_wr");
        end
    endtask

    initial begin
        test_reset();
        test_read_vector();
        test_write_gaps();
        test_both_strobes();
        test_stray_resp();
        test_reset_mid_read();
`ifdef BURST_LINE_ADAPTER_POSTED_WRITE_EN
        test_posted_then_read();
`endif
        test_random_mix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
